store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending-store entries (power of two, 2..16).
REQ-002 SHALL have clk input 1: clock; all state updates on its rising edge.
REQ-003 SHALL have reset input 1: reset, synchronous, active-high.
REQ-004 SHALL have st_valid input 1: MEM stage presents a store this cycle.
REQ-005 SHALL have st_addr input 32: store byte address; any alignment allowed.
REQ-006 SHALL have st_data input 32: store data, bytes LSB-first.
REQ-007 SHALL have st_size input 3: bytes to store; legal values 1, 2, 4.
REQ-008 SHALL have st_ready output 1: a store is accepted this cycle when st_valid is also high.
REQ-009 SHALL have st_err output 1: one-cycle pulse on an illegal st_size.
REQ-010 SHALL have ld_valid input 1: MEM stage presents a word load this cycle.
REQ-011 SHALL have ld_addr input 32: load byte address; the load reads 4 bytes from ld_addr.
REQ-012 SHALL have ld_stall output 1: the load overlaps a pending store and must be held.
REQ-013 SHALL have dm_address output 32: address to the data memory.
REQ-014 SHALL have dm_data_in output 32: write data to the data memory.
REQ-015 SHALL have dm_size output 3: write byte count to the data memory; 0 means no write.
REQ-016 SHALL have count output $clog2(DEPTH)+1: number of occupied entries.
REQ-017 SHALL have empty output 1: count==0, used to drain stores before syscall/eret.

Function
REQ-018 SHALL hold entries {addr, data, size} in a circular FIFO with head and tail pointers that wrap modulo DEPTH.
REQ-019 SHALL drive st_ready = !reset && count<DEPTH; a full buffer does not accept a store, even if it drains in the same cycle.
REQ-020 SHALL enqueue at tail on st_valid && st_ready && st_size in {1,2,4}; the new entry becomes visible to the overlap check in the next cycle.
REQ-021 SHALL not enqueue when st_valid && st_ready && st_size not in {1,2,4}; it SHALL assert st_err for exactly that cycle.
REQ-022 SHALL mark a load as overlapping when any occupied entry satisfies e.addr < ld_addr+4 and ld_addr < e.addr+e.size, evaluated in 33-bit unsigned arithmetic (no wrap).
REQ-023 SHALL drive ld_stall = ld_valid && overlap, combinationally in the same cycle.
REQ-024 SHALL drain the head entry in a cycle when count>0 and (!ld_valid || ld_stall); this guarantees forward progress with no deadlock.
REQ-025 In a drain cycle, dm_address=head.addr, dm_data_in=head.data, dm_size=head.size, and head advances at the clock edge.
REQ-026 In a non-drain cycle, dm_address=ld_addr, dm_data_in=0, dm_size=0; the port then serves the load or idles.
REQ-027 SHALL allow an enqueue and a drain in the same cycle (count unchanged) when count<DEPTH.
REQ-028 SHALL preserve program order: stores reach the data memory strictly in enqueue order, one per drain cycle, with latency ≥1 cycle after acceptance.
REQ-029 SHALL pass st_addr and st_data unmodified; byte placement is done by the data memory.
REQ-030 SHALL update count as count + enqueue − drain, bounded to 0..DEPTH.

Reset
REQ-031 While reset is high at a clock edge, the block SHALL set head=tail=0, count=0 and clear all entries.
REQ-032 While reset is high, outputs SHALL be st_ready=0, st_err=0, ld_stall=0, dm_size=0, dm_data_in=0, empty=1, and enqueue is ignored.
REQ-033 Reset asserted mid-operation SHALL discard all pending stores with no partial write; dm_size=0 from the reset cycle on.

Verification
REQ-034 The bench SHALL cover single store then idle: sw addr 0x10 data 0xDEADBEEF size 4.
  - Next cycle: dm_address=0x10, dm_size=4, dm_data_in=0xDEADBEEF.
  - The cycle after: empty=1.
REQ-035 The bench SHALL cover fill to full: 4 stores with ld_valid held high and no overlap.
  - st_ready=0 and count=4; a 5th st_valid is not accepted.
  - After ld_valid drops, 4 consecutive drains in order follow.
REQ-036 The bench SHALL cover load overlap: pending sb addr 0x23, then lw ld_addr 0x20.
  - ld_stall=1 and the sb drains in the same cycle.
  - Next cycle: ld_stall=0 and dm_address=0x20 with dm_size=0.
REQ-037 The bench SHALL cover an unaligned boundary: pending sh addr 0x1F (bytes 0x1F..0x20).
  - Loads at 0x1C and 0x20 both stall.
  - A load at 0x24 does not stall.
REQ-038 The bench SHALL cover an illegal size: st_size=3 with st_valid=1.
  - st_err=1 for one cycle; count unchanged.
REQ-039 The bench SHALL cover reset with 3 entries pending.
  - Next cycle: count=0, empty=1, dm_size=0, and no queued store ever reaches the data memory.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of pending stores between the MEM stage and the
// data memory. Stores drain one per cycle whenever the memory port is not
// needed by a load; a load that overlaps any pending store is stalled, which
// in turn frees the port so the head store drains and progress is guaranteed.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   st_valid/addr/data/size    store request from MEM (size 1, 2 or 4 bytes)
//   st_ready                   store accepted when st_valid is also high
//   st_err                     pulse for an illegal st_size on an accepted slot
//   ld_valid/ld_addr           word load request from MEM
//   ld_stall                   load overlaps a pending store and must be held
//   dm_address/data_in/size    data memory port (dm_size 0 = no write)
//   count, empty               occupancy, empty used to drain before syscall/eret
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [2:0]               st_size,
  output logic                     st_ready,
  output logic                     st_err,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  output logic                     ld_stall,
  output logic [31:0]              dm_address,
  output logic [31:0]              dm_data_in,
  output logic [2:0]               dm_size,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [2:0]       size_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  logic             size_legal;
  logic             enq;
  logic             drain;
  logic             overlap;
  logic [DEPTH-1:0] hit;
  logic [32:0]      ld_lo;
  logic [32:0]      ld_hi;

  // Load byte range [ld_lo, ld_hi) in 33 bits so the end never wraps.
  assign ld_lo = {1'b0, ld_addr};
  assign ld_hi = ld_lo + 33'd4;

  // Per-entry half-open interval intersection test.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    logic [32:0] e_lo;
    logic [32:0] e_hi;
    assign e_lo   = {1'b0, addr_q[i]};
    assign e_hi   = e_lo + 33'(size_q[i]);
    assign hit[i] = vld_q[i] && (e_lo < ld_hi) && (ld_lo < e_hi);
  end

  assign overlap    = |hit;
  assign size_legal = (st_size == 3'd1) || (st_size == 3'd2) || (st_size == 3'd4);

  // A full buffer refuses stores even when it drains this same cycle.
  assign st_ready = !reset && (count_q < CW'(DEPTH));
  assign enq      = st_valid && st_ready && size_legal;
  assign st_err   = st_valid && st_ready && !size_legal;
  assign ld_stall = !reset && ld_valid && overlap;

  // A stalled load leaves the port free, so the head drains and clears the hazard.
  assign drain = !reset && (count_q != '0) && (!ld_valid || ld_stall);

  assign dm_address = drain ? addr_q[head_q] : ld_addr;
  assign dm_data_in = drain ? data_q[head_q] : 32'd0;
  assign dm_size    = drain ? size_q[head_q] : 3'd0;
  assign count      = count_q;
  assign empty      = reset || (count_q == '0);

  // FIFO storage and pointers; enqueue and drain never target the same slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        addr_q[tail_q] <= st_addr;
        data_q[tail_q] <= st_data;
        size_q[tail_q] <= st_size;
        vld_q[tail_q]  <= 1'b1;
        tail_q         <= tail_q + PW'(1);
      end
      if (drain) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      count_q <= count_q + CW'(enq) - CW'(drain);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios for store_buffer (DEPTH=4). Inputs are
// driven just after the falling edge and outputs sampled 1 ns later, so each
// block of checks sees the combinational outputs for the cycle whose inputs
// are applied at the following rising edge.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_size;
  logic        st_ready;
  logic        st_err;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic [31:0] dm_address;
  logic [31:0] dm_data_in;
  logic [2:0]  dm_size;
  logic [2:0]  count;
  logic        empty;

  int n_cmp = 0;
  int n_err = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_size    (st_size),
    .st_ready   (st_ready),
    .st_err     (st_err),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_stall   (ld_stall),
    .dm_address (dm_address),
    .dm_data_in (dm_data_in),
    .dm_size    (dm_size),
    .count      (count),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic store_in(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    store_in(32'h10, 32'h1, 3'd4);
    ld_valid = 1'b1;
    ld_addr  = 32'h10;
    @(negedge clk); #1;
    n_cmp++; if (st_ready !== 1'b0) begin n_err++; $display("FAIL reset_st_ready: got %b want 0", st_ready); end
    n_cmp++; if (st_err !== 1'b0) begin n_err++; $display("FAIL reset_st_err: got %b want 0", st_err); end
    n_cmp++; if (ld_stall !== 1'b0) begin n_err++; $display("FAIL reset_ld_stall: got %b want 0", ld_stall); end
    n_cmp++; if (dm_size !== 3'd0) begin n_err++; $display("FAIL reset_dm_size: got %0d want 0", dm_size); end
    n_cmp++; if (dm_data_in !== 32'd0) begin n_err++; $display("FAIL reset_dm_data: got %h want 0", dm_data_in); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    @(negedge clk);
    reset    = 1'b0;
    st_valid = 1'b0;
    ld_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty_after: got %b want 1", empty); end
  endtask

  task automatic test_single_store;
    @(negedge clk);
    store_in(32'h10, 32'hDEADBEEF, 3'd4);
    ld_valid = 1'b0;
    #1;
    n_cmp++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", st_ready); end
    n_cmp++; if (dm_size !== 3'd0) begin n_err++; $display("FAIL single_no_early_write: got %0d want 0", dm_size); end
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    n_cmp++; if (dm_address !== 32'h10) begin n_err++; $display("FAIL single_addr: got %h want 00000010", dm_address); end
    n_cmp++; if (dm_size !== 3'd4) begin n_err++; $display("FAIL single_size: got %0d want 4", dm_size); end
    n_cmp++; if (dm_data_in !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", dm_data_in); end
    @(negedge clk); #1;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b want 1", empty); end
    n_cmp++; if (dm_size !== 3'd0) begin n_err++; $display("FAIL single_idle_size: got %0d want 0", dm_size); end
  endtask

  task automatic test_fill_full;
    logic [31:0] d;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      d = 32'h11111111 * 32'(k + 1);
      store_in(32'(4 * k), d, 3'd4);
      ld_valid = 1'b1;
      ld_addr  = 32'h100;
      #1;
      n_cmp++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d]: got %b want 1", k, st_ready); end
      n_cmp++; if (dm_size !== 3'd0) begin n_err++; $display("FAIL fill_no_drain[%0d]: got %0d want 0", k, dm_size); end
    end
    @(negedge clk);
    store_in(32'h40, 32'h55555555, 3'd4);
    #1;
    n_cmp++; if (st_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", st_ready); end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", count); end
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_fifth_rejected: got %0d want 4", count); end
    ld_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      d = 32'h11111111 * 32'(k + 1);
      n_cmp++; if (dm_address !== 32'(4 * k)) begin n_err++; $display("FAIL drain_addr[%0d]: got %h want %h", k, dm_address, 32'(4 * k)); end
      n_cmp++; if (dm_data_in !== d) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", k, dm_data_in, d); end
      n_cmp++; if (dm_size !== 3'd4) begin n_err++; $display("FAIL drain_size[%0d]: got %0d want 4", k, dm_size); end
    end
    @(negedge clk); #1;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_load_overlap;
    @(negedge clk);
    store_in(32'h23, 32'h000000AB, 3'd1);
    ld_valid = 1'b0;
    @(negedge clk);
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h20;
    #1;
    n_cmp++; if (ld_stall !== 1'b1) begin n_err++; $display("FAIL ovl_stall: got %b want 1", ld_stall); end
    n_cmp++; if (dm_address !== 32'h23) begin n_err++; $display("FAIL ovl_drain_addr: got %h want 00000023", dm_address); end
    n_cmp++; if (dm_size !== 3'd1) begin n_err++; $display("FAIL ovl_drain_size: got %0d want 1", dm_size); end
    n_cmp++; if (dm_data_in !== 32'hAB) begin n_err++; $display("FAIL ovl_drain_data: got %h want 000000ab", dm_data_in); end
    @(negedge clk); #1;
    n_cmp++; if (ld_stall !== 1'b0) begin n_err++; $display("FAIL ovl_released: got %b want 0", ld_stall); end
    n_cmp++; if (dm_address !== 32'h20) begin n_err++; $display("FAIL ovl_load_addr: got %h want 00000020", dm_address); end
    n_cmp++; if (dm_size !== 3'd0) begin n_err++; $display("FAIL ovl_load_size: got %0d want 0", dm_size); end
    ld_valid = 1'b0;
  endtask

  task automatic test_boundary;
    @(negedge clk);
    store_in(32'h1F, 32'h0000BEEF, 3'd2);
    ld_valid = 1'b1;
    ld_addr  = 32'h100;
    @(negedge clk);
    st_valid = 1'b0;
    ld_addr  = 32'h1B;
    #1;
    n_cmp++; if (ld_stall !== 1'b0) begin n_err++; $display("FAIL bnd_1b_stall: got %b want 0", ld_stall); end
    ld_addr = 32'h24;
    #1;
    n_cmp++; if (ld_stall !== 1'b0) begin n_err++; $display("FAIL bnd_24_stall: got %b want 0", ld_stall); end
    n_cmp++; if (dm_size !== 3'd0) begin n_err++; $display("FAIL bnd_24_size: got %0d want 0", dm_size); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL bnd_count: got %0d want 1", count); end
    @(negedge clk);
    ld_addr = 32'h1C;
    #1;
    n_cmp++; if (ld_stall !== 1'b1) begin n_err++; $display("FAIL bnd_1c_stall: got %b want 1", ld_stall); end
    ld_addr = 32'h20;
    #1;
    n_cmp++; if (ld_stall !== 1'b1) begin n_err++; $display("FAIL bnd_20_stall: got %b want 1", ld_stall); end
    n_cmp++; if (dm_address !== 32'h1F) begin n_err++; $display("FAIL bnd_drain_addr: got %h want 0000001f", dm_address); end
    n_cmp++; if (dm_size !== 3'd2) begin n_err++; $display("FAIL bnd_drain_size: got %0d want 2", dm_size); end
    n_cmp++; if (dm_data_in !== 32'hBEEF) begin n_err++; $display("FAIL bnd_drain_data: got %h want 0000beef", dm_data_in); end
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL bnd_empty: got %b want 1", empty); end
  endtask

  task automatic test_illegal_and_back_to_back;
    @(negedge clk);
    store_in(32'h200, 32'h12345678, 3'd4);
    ld_valid = 1'b1;
    ld_addr  = 32'h100;
    @(negedge clk);
    store_in(32'h300, 32'h99999999, 3'd3);
    #1;
    n_cmp++; if (st_err !== 1'b1) begin n_err++; $display("FAIL ill_err: got %b want 1", st_err); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL ill_count_before: got %0d want 1", count); end
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    n_cmp++; if (st_err !== 1'b0) begin n_err++; $display("FAIL ill_err_pulse: got %b want 0", st_err); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL ill_count_after: got %0d want 1", count); end
    @(negedge clk);
    ld_valid = 1'b0;
    store_in(32'h204, 32'h0000CAFE, 3'd2);
    #1;
    n_cmp++; if (dm_address !== 32'h200) begin n_err++; $display("FAIL b2b_drain_addr: got %h want 00000200", dm_address); end
    n_cmp++; if (dm_data_in !== 32'h12345678) begin n_err++; $display("FAIL b2b_drain_data: got %h want 12345678", dm_data_in); end
    n_cmp++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", st_ready); end
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL b2b_count: got %0d want 1", count); end
    n_cmp++; if (dm_address !== 32'h204) begin n_err++; $display("FAIL b2b_next_addr: got %h want 00000204", dm_address); end
    n_cmp++; if (dm_size !== 3'd2) begin n_err++; $display("FAIL b2b_next_size: got %0d want 2", dm_size); end
    @(negedge clk); #1;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", empty); end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      store_in(32'h300 + 32'(4 * k), 32'hA0A0A0A0 + 32'(k), 3'd4);
      ld_valid = 1'b1;
      ld_addr  = 32'h100;
    end
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL rst_mid_pending: got %0d want 3", count); end
    @(negedge clk);
    reset    = 1'b1;
    ld_valid = 1'b0;
    store_in(32'h400, 32'h77777777, 3'd4);
    #1;
    n_cmp++; if (dm_size !== 3'd0) begin n_err++; $display("FAIL rst_mid_size: got %0d want 0", dm_size); end
    n_cmp++; if (dm_data_in !== 32'd0) begin n_err++; $display("FAIL rst_mid_data: got %h want 0", dm_data_in); end
    n_cmp++; if (st_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready: got %b want 0", st_ready); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_mid_empty: got %b want 1", empty); end
    @(negedge clk);
    reset    = 1'b0;
    st_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_mid_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_mid_empty_after: got %b want 1", empty); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_cmp++; if (dm_size !== 3'd0) begin n_err++; $display("FAIL rst_mid_no_write[%0d]: got %0d want 0", k, dm_size); end
    end
  endtask

  initial begin
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_size  = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    reset    = 1'b1;
    test_reset();
    test_single_store();
    test_fill_full();
    test_load_overlap();
    test_boundary();
    test_illegal_and_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
